// File: rtl/fwrisc_mem_arb.sv
// Arbiter sharing one memory port between the fetch and data sides.
// Supports fixed data priority or round-robin, a stall timeout and request abort.
module fwrisc_mem_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          DATA_PRIORITY  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic [31:0] idata,
    output logic        iready,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dstrb,
    input  logic        dwrite,
    input  logic        dvalid,
    output logic [31:0] drdata,
    output logic        dready,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mstrb,
    output logic        mwrite,
    output logic        mvalid,
    input  logic [31:0] mrdata,
    input  logic        mready,
    output logic [1:0]  owner,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              last_grant_q, last_grant_d;   // 1 = data was granted last

    logic owner_valid;
    logic timeout;
    logic done;

    // The current owner's request qualifies the whole grant; dropping it aborts.
    assign owner_valid = ((state_q == GNT_I) && ivalid) || ((state_q == GNT_D) && dvalid);
    assign timeout     = TIMEOUT_EN && owner_valid && !mready && (stall_cnt_q == TIMEOUT_VAL);
    assign done        = owner_valid && (mready || timeout);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            stall_cnt_q  <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                stall_cnt_d = '0;
                if (ivalid && dvalid) begin
                    if (DATA_PRIORITY || !last_grant_q) begin
                        state_d      = GNT_D;
                        last_grant_d = 1'b1;
                    end else begin
                        state_d      = GNT_I;
                        last_grant_d = 1'b0;
                    end
                end else if (ivalid) begin
                    state_d      = GNT_I;
                    last_grant_d = 1'b0;
                end else if (dvalid) begin
                    state_d      = GNT_D;
                    last_grant_d = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (!owner_valid || done) begin
                    state_d = IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner   = state_q;
        mvalid  = owner_valid;
        maddr   = '0;
        mwdata  = '0;
        mstrb   = '0;
        mwrite  = 1'b0;
        iready  = (state_q == GNT_I) && done;
        dready  = (state_q == GNT_D) && done;
        bus_err = timeout;
        idata   = timeout ? 32'hDEAD_BEEF : mrdata;
        drdata  = timeout ? 32'hDEAD_BEEF : mrdata;
        case (state_q)
            GNT_I: begin
                maddr = iaddr;
                mstrb = 4'hf;
            end
            GNT_D: begin
                maddr  = daddr;
                mwdata = dwdata;
                mstrb  = dstrb;
                mwrite = dwrite;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// Directed bench for fwrisc_mem_arb: one fixed-priority and one round-robin
// instance, both with a short stall timeout, driven from shared inputs.
module tb_fwrisc_mem_arb;

    logic        clock;
    logic        reset;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dstrb;
    logic        dwrite;
    logic        dvalid;
    logic [31:0] mrdata;
    logic        mready;

    logic [31:0] p_idata, p_drdata, p_maddr, p_mwdata;
    logic        p_iready, p_dready, p_mwrite, p_mvalid, p_bus_err;
    logic [3:0]  p_mstrb;
    logic [1:0]  p_owner;

    logic [31:0] rr_idata, rr_drdata, rr_maddr, rr_mwdata;
    logic        rr_iready, rr_dready, rr_mwrite, rr_mvalid, rr_bus_err;
    logic [3:0]  rr_mstrb;
    logic [1:0]  rr_owner;

    int errors = 0;
    int checks = 0;

    fwrisc_mem_arb #(.TIMEOUT_CYCLES(4), .DATA_PRIORITY(1'b1)) dut_p (
        .clock(clock), .reset(reset),
        .iaddr(iaddr), .ivalid(ivalid), .idata(p_idata), .iready(p_iready),
        .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb), .dwrite(dwrite), .dvalid(dvalid),
        .drdata(p_drdata), .dready(p_dready),
        .maddr(p_maddr), .mwdata(p_mwdata), .mstrb(p_mstrb), .mwrite(p_mwrite), .mvalid(p_mvalid),
        .mrdata(mrdata), .mready(mready), .owner(p_owner), .bus_err(p_bus_err)
    );

    fwrisc_mem_arb #(.TIMEOUT_CYCLES(4), .DATA_PRIORITY(1'b0)) dut_rr (
        .clock(clock), .reset(reset),
        .iaddr(iaddr), .ivalid(ivalid), .idata(rr_idata), .iready(rr_iready),
        .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb), .dwrite(dwrite), .dvalid(dvalid),
        .drdata(rr_drdata), .dready(rr_dready),
        .maddr(rr_maddr), .mwdata(rr_mwdata), .mstrb(rr_mstrb), .mwrite(rr_mwrite), .mvalid(rr_mvalid),
        .mrdata(mrdata), .mready(mready), .owner(rr_owner), .bus_err(rr_bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle's inputs at the falling edge and lets the combinational outputs settle.
    task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                                 input logic dv, input logic dw, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [3:0] ds,
                                 input logic mr, input logic [31:0] mrd);
        @(negedge clock);
        ivalid = iv; iaddr = ia;
        dvalid = dv; dwrite = dw; daddr = da; dwdata = dwd; dstrb = ds;
        mready = mr; mrdata = mrd;
        #1;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        ivalid = 1'b0; dvalid = 1'b0; mready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] rr_exp [8];
        logic [1:0] p_exp  [8];
        rr_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        p_exp  = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
        reset = 1'b1;
        iaddr = '0; ivalid = 1'b0; daddr = '0; dwdata = '0; dstrb = '0;
        dwrite = 1'b0; dvalid = 1'b0; mrdata = '0; mready = 1'b0;

        // Reset state, with a stray mready in IDLE
        doReset();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h5555_5555);
        checkOutput("rst_owner",  {30'h0, p_owner}, 32'h0);
        checkOutput("rst_mvalid", {31'h0, p_mvalid}, 32'h0);
        checkOutput("rst_iready", {31'h0, p_iready}, 32'h0);
        checkOutput("rst_dready", {31'h0, p_dready}, 32'h0);
        checkOutput("rst_buserr", {31'h0, p_bus_err}, 32'h0);
        checkOutput("rr_rst_owner", {30'h0, rr_owner}, 32'h0);

        // Fetch-only transfer
        applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        checkOutput("f_idle_mvalid", {31'h0, p_mvalid}, 32'h0);
        applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0000_0013);
        checkOutput("f_owner",  {30'h0, p_owner}, 32'h1);
        checkOutput("f_mvalid", {31'h0, p_mvalid}, 32'h1);
        checkOutput("f_maddr",  p_maddr, 32'h100);
        checkOutput("f_mwrite", {31'h0, p_mwrite}, 32'h0);
        checkOutput("f_mstrb",  {28'h0, p_mstrb}, 32'hf);
        checkOutput("f_mwdata", p_mwdata, 32'h0);
        checkOutput("f_iready", {31'h0, p_iready}, 32'h1);
        checkOutput("f_dready", {31'h0, p_dready}, 32'h0);
        checkOutput("f_idata",  p_idata, 32'h13);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        checkOutput("f_after_owner", {30'h0, p_owner}, 32'h0);

        // Contention under fixed data priority
        doReset();
        applyStimulus(1, 32'h300, 1, 1, 32'h2000, 32'hA5A5_A5A5, 4'h3, 0, 32'h0);
        checkOutput("c_idle_owner", {30'h0, p_owner}, 32'h0);
        applyStimulus(1, 32'h300, 1, 1, 32'h2000, 32'hA5A5_A5A5, 4'h3, 1, 32'h0);
        checkOutput("c_owner",  {30'h0, p_owner}, 32'h2);
        checkOutput("c_maddr",  p_maddr, 32'h2000);
        checkOutput("c_mwdata", p_mwdata, 32'hA5A5_A5A5);
        checkOutput("c_mwrite", {31'h0, p_mwrite}, 32'h1);
        checkOutput("c_mstrb",  {28'h0, p_mstrb}, 32'h3);
        checkOutput("c_dready", {31'h0, p_dready}, 32'h1);
        checkOutput("c_iready", {31'h0, p_iready}, 32'h0);
        applyStimulus(1, 32'h300, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        checkOutput("c_gap_owner", {30'h0, p_owner}, 32'h0);
        applyStimulus(1, 32'h300, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h77);
        checkOutput("c_i_owner",  {30'h0, p_owner}, 32'h1);
        checkOutput("c_i_maddr",  p_maddr, 32'h300);
        checkOutput("c_i_iready", {31'h0, p_iready}, 32'h1);

        // Round-robin versus fixed priority with both sides always requesting
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 32'h300, 1, 1, 32'h400, 32'h0, 4'hf, 1, 32'h1000 + k);
            checkOutput($sformatf("rr_owner%0d", k), {30'h0, rr_owner}, {30'h0, rr_exp[k]});
            checkOutput($sformatf("p_owner%0d", k),  {30'h0, p_owner},  {30'h0, p_exp[k]});
            checkOutput($sformatf("rr_iready%0d", k), {31'h0, rr_iready}, {31'h0, rr_exp[k] == 2'b01});
            checkOutput($sformatf("rr_dready%0d", k), {31'h0, rr_dready}, {31'h0, rr_exp[k] == 2'b10});
            if (rr_exp[k] == 2'b01) begin
                checkOutput($sformatf("rr_iaddr%0d", k), rr_maddr, 32'h300);
                checkOutput($sformatf("rr_idata%0d", k), rr_idata, 32'h1000 + k);
            end
            if (rr_exp[k] == 2'b10) begin
                checkOutput($sformatf("rr_daddr%0d", k), rr_maddr, 32'h400);
                checkOutput($sformatf("rr_drdata%0d", k), rr_drdata, 32'h1000 + k);
            end
        end

        // Timeout after four stalled cycles
        doReset();
        applyStimulus(0, 32'h0, 1, 0, 32'h40, 32'h0, 4'hf, 0, 32'h1234_5678);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 32'h0, 1, 0, 32'h40, 32'h0, 4'hf, 0, 32'h1234_5678);
            checkOutput($sformatf("t_stall_dready%0d", k), {31'h0, p_dready}, 32'h0);
            checkOutput($sformatf("t_stall_err%0d", k), {31'h0, p_bus_err}, 32'h0);
        end
        applyStimulus(0, 32'h0, 1, 0, 32'h40, 32'h0, 4'hf, 0, 32'h1234_5678);
        checkOutput("t_dready", {31'h0, p_dready}, 32'h1);
        checkOutput("t_drdata", p_drdata, 32'hDEAD_BEEF);
        checkOutput("t_buserr", {31'h0, p_bus_err}, 32'h1);
        checkOutput("t_mvalid", {31'h0, p_mvalid}, 32'h1);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        checkOutput("t_after_owner", {30'h0, p_owner}, 32'h0);
        checkOutput("t_after_err", {31'h0, p_bus_err}, 32'h0);

        // mready arriving on the timeout cycle wins
        doReset();
        for (int k = 0; k < 5; k++)
            applyStimulus(0, 32'h0, 1, 0, 32'h40, 32'h0, 4'hf, 0, 32'h0);
        applyStimulus(0, 32'h0, 1, 0, 32'h40, 32'h0, 4'hf, 1, 32'hCAFE_0001);
        checkOutput("tm_dready", {31'h0, p_dready}, 32'h1);
        checkOutput("tm_drdata", p_drdata, 32'hCAFE_0001);
        checkOutput("tm_buserr", {31'h0, p_bus_err}, 32'h0);

        // Fetch abort while granted
        doReset();
        applyStimulus(1, 32'h500, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        applyStimulus(0, 32'h500, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h99);
        checkOutput("a_owner",  {30'h0, p_owner}, 32'h1);
        checkOutput("a_mvalid", {31'h0, p_mvalid}, 32'h0);
        checkOutput("a_iready", {31'h0, p_iready}, 32'h0);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        checkOutput("a_after_owner", {30'h0, p_owner}, 32'h0);

        // Reset during a stalled data grant
        doReset();
        applyStimulus(0, 32'h0, 1, 1, 32'h80, 32'h1, 4'h1, 0, 32'h0);
        applyStimulus(0, 32'h0, 1, 1, 32'h80, 32'h1, 4'h1, 0, 32'h0);
        checkOutput("r_owner", {30'h0, p_owner}, 32'h2);
        checkOutput("r_dready0", {31'h0, p_dready}, 32'h0);
        applyStimulus(0, 32'h0, 1, 1, 32'h80, 32'h1, 4'h1, 0, 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("r_dready1", {31'h0, p_dready}, 32'h0);
        applyStimulus(0, 32'h0, 1, 1, 32'h80, 32'h1, 4'h1, 0, 32'h0);
        checkOutput("r_after_owner",  {30'h0, p_owner}, 32'h0);
        checkOutput("r_after_mvalid", {31'h0, p_mvalid}, 32'h0);
        checkOutput("r_after_dready", {31'h0, p_dready}, 32'h0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwrisc_mem_arb.md
FWRISC_MEM_ARB -- requirements
Module: fwrisc_mem_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the stall cycles before forced completion; a value of 0 disables the timeout.
REQ-002 The block SHALL have parameter DATA_PRIORITY, default 1; 1 selects fixed data-side priority, 0 selects round-robin.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- iaddr  in  32  instruction fetch address.
- ivalid  in  1  fetch request.
- idata  out  32  fetch read data.
- iready  out  1  fetch completion strobe.
- daddr  in  32  data address, word-aligned.
- dwdata  in  32  data write data.
- dstrb  in  4  byte strobes.
- dwrite  in  1  1 = write, 0 = read.
- dvalid  in  1  data request.
- drdata  out  32  data read data.
- dready  out  1  data completion strobe.
- maddr  out  32  shared memory address.
- mwdata  out  32  shared memory write data.
- mstrb  out  4  shared memory strobes.
- mwrite  out  1  shared memory write enable.
- mvalid  out  1  shared memory request.
- mrdata  in  32  shared memory read data.
- mready  in  1  shared memory completion.
- owner  out  2  current owner: 00 none, 01 fetch, 10 data.
- bus_err  out  1  one-cycle pulse on timeout.

Function
REQ-004 The block SHALL implement states IDLE, GNT_I, GNT_D; the owner output SHALL encode them as 00, 01, 10.
REQ-005 In IDLE, mvalid=0, iready=0 and dready=0.
REQ-006 In IDLE with only ivalid=1, the next state SHALL be GNT_I.
REQ-007 In IDLE with only dvalid=1, the next state SHALL be GNT_D.
REQ-008 In IDLE with both valids high and DATA_PRIORITY=1, the next state SHALL be GNT_D.
REQ-009 In IDLE with both valids high and DATA_PRIORITY=0, the block SHALL grant the side not granted last; a last_grant register SHALL reset to data, so the first contested grant goes to fetch.
REQ-010 In GNT_I, mvalid=1, maddr=iaddr, mwrite=0, mstrb=4'hf and mwdata=0, all combinational from the inputs.
REQ-011 In GNT_D, mvalid=1, maddr=daddr, mwdata=dwdata, mstrb=dstrb and mwrite=dwrite, all combinational from the inputs.
REQ-012 The owner's ready output SHALL equal mready while in its GNT state; the non-owner's ready SHALL be 0.
REQ-013 idata SHALL be driven from mrdata; drdata SHALL be driven from mrdata.
REQ-014 A cycle with mvalid&&mready SHALL complete the transfer and return the state to IDLE on the next edge, with no back-to-back regrant.
REQ-015 Minimum latency SHALL be 2 cycles from request to ready: valid sampled in IDLE, then mvalid with mready in the following cycle.
REQ-016 A stall counter (8 bits minimum, wide enough for TIMEOUT_CYCLES) SHALL clear on entry to any GNT state and increment on each GNT cycle with mready=0.
REQ-017 When TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES with mready=0, the block SHALL do all of the following in that same cycle:
- assert the owner's ready;
- force idata/drdata to 32'hDEAD_BEEF;
- pulse bus_err=1;
- return to IDLE next.
REQ-018 mvalid SHALL remain 1 during the timeout cycle.
REQ-019 If the owner drops its valid while in GNT, mvalid SHALL go 0 that cycle, no ready SHALL be issued, and the next state SHALL be IDLE (abort).
REQ-020 mready while in IDLE SHALL be ignored.
REQ-021 Simultaneous mready and timeout SHALL be treated as a normal completion, with real data and no bus_err.

Reset
REQ-022 While reset=1 at a clock edge, the block SHALL:
- set the state to IDLE;
- clear the counter;
- set last_grant to data;
- drive owner=00, mvalid=0, iready=0, dready=0 and bus_err=0 on the following cycle.
REQ-023 Reset asserted during GNT SHALL abandon the transfer without issuing ready.

Verification
REQ-024 Fetch-only: ivalid=1, iaddr=0x100, mready=1 one cycle after grant, mrdata=0x00000013 -> maddr=0x100 and mwrite=0 in the GNT_I cycle; iready=1 with idata=0x13 in that cycle; owner=00 the next cycle.
REQ-025 Contention with DATA_PRIORITY=1: ivalid=dvalid=1 in IDLE, dwrite=1, daddr=0x2000, dwdata=0xA5A5A5A5, dstrb=4'h3 -> GNT_D first; mwrite=1 and mstrb=4'h3; after dready, IDLE for one cycle, then GNT_I.
REQ-026 Round-robin with DATA_PRIORITY=0: both valids held high for 4 transfers -> grant order fetch, data, fetch, data.
REQ-027 Timeout with TIMEOUT_CYCLES=4: dvalid=1, mready held 0 -> dready=1, drdata=0xDEADBEEF and bus_err=1 in the same cycle (the 5th GNT_D cycle); IDLE next.
REQ-028 Abort and reset: in GNT_I, drop ivalid -> mvalid=0 and no iready; separately, assert reset during GNT_D with a stalled mready -> owner=00 and mvalid=0 after the edge, and dready is never asserted.
